// File: rtl/accel_tilt_mapper.sv
// Accelerometer frame assembler and tilt-to-LED-matrix index mapper.
// Latency: sample_o commits on the edge accepting the last byte; indices follow one edge later.
// Backpressure: none; bytes are taken whenever enable_i is high. Optional IIR: ACCEL_TILT_IIR_EN.
module accel_tilt_mapper #(
  parameter int NUM_AXES    = 3,
  parameter int SAMPLE_W    = 10,
  parameter int COLS        = 6,
  parameter int ROWS        = 2,
  parameter int COL_SHIFT   = 6,
  parameter int ROW_SHIFT   = 9,
  parameter int ALPHA_SHIFT = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [7:0]                   data_i,
  input  logic                         enable_i,
  input  logic                         frame_start_i,
  output logic [NUM_AXES*SAMPLE_W-1:0] sample_o,
  output logic                         sample_valid_o,
  output logic [$clog2(ROWS)-1:0]      row_index_o,
  output logic [$clog2(COLS)-1:0]      column_index_o,
  output logic                         pos_valid_o
);

  localparam int BPA         = 2;
  localparam int FRAME_BYTES = NUM_AXES * BPA;
  localparam int CNT_W       = $clog2(FRAME_BYTES);
  localparam int AX_W        = CNT_W - 1;
  localparam int SMP_W       = NUM_AXES * SAMPLE_W;
  localparam int MW          = SAMPLE_W + 2;
  localparam int CW          = $clog2(COLS);
  localparam int RW          = $clog2(ROWS);

  localparam logic signed [MW-1:0] COL_OFF = MW'(COLS / 2);
  localparam logic signed [MW-1:0] ROW_OFF = MW'(ROWS / 2);
  localparam logic signed [MW-1:0] COL_MAX = MW'(COLS - 1);
  localparam logic signed [MW-1:0] ROW_MAX = MW'(ROWS - 1);

  // ---------------------------------------------------------------------------
  // Byte assembly
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SMP_W-1:0] shadow_q, shadow_d;
  logic [SMP_W-1:0] sample_q, sample_d;
  logic             sample_valid_q, sample_valid_d;

  logic [CNT_W-1:0] idx;
  logic [AX_W-1:0]  axis;
  logic             hi_byte;
  logic             last_byte;
  int               base;

  // Byte placement, counter advance and atomic commit on the final byte.
  always_comb begin
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    // A resync byte is always byte 0, so it can never be treated as the last byte.
    idx            = frame_start_i ? '0 : cnt_q;
    axis           = idx[CNT_W-1:1];
    hi_byte        = idx[0];
    last_byte      = (idx == CNT_W'(FRAME_BYTES - 1));
    base           = int'(axis) * SAMPLE_W;
    if (enable_i) begin
      if (!hi_byte) begin
        shadow_d[base +: 8] = data_i;
      end else begin
        // Only the low SAMPLE_W-8 bits of the high byte carry sample data.
        shadow_d[base + 8 +: SAMPLE_W - 8] = data_i[SAMPLE_W-9:0];
      end
      if (last_byte) begin
        cnt_d          = '0;
        sample_d       = shadow_d;
        sample_valid_d = 1'b1;
      end else begin
        cnt_d = idx + CNT_W'(1);
      end
    end else if (frame_start_i) begin
      cnt_d = '0;
    end
  end

  // Assembly state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q          <= '0;
      shadow_q       <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Source of the X/Y values fed to the mapper
  // ---------------------------------------------------------------------------
  logic [SAMPLE_W-1:0] map_x;
  logic [SAMPLE_W-1:0] map_y;
  logic                map_vld;

`ifdef ACCEL_TILT_IIR_EN
  // Filter state keeps ALPHA_SHIFT fraction bits so small steps are not lost.
  localparam int FW = SAMPLE_W + ALPHA_SHIFT;

  logic signed [FW-1:0] fx_q, fx_d, fy_q, fy_d;
  logic                 finit_q;
  logic                 fvld_q;

  function automatic logic signed [FW-1:0] iir_step(input logic signed [FW-1:0] f,
                                                    input logic [SAMPLE_W-1:0] s);
    logic signed [FW:0] s_ext;
    logic signed [FW:0] diff;
    s_ext    = {s[SAMPLE_W-1], s, {ALPHA_SHIFT{1'b0}}};
    diff     = s_ext - {f[FW-1], f};
    iir_step = f + FW'(diff >>> ALPHA_SHIFT);
  endfunction

  // Next filter value; the first commit after reset seeds the filter directly.
  always_comb begin
    fx_d = fx_q;
    fy_d = fy_q;
    if (!finit_q) begin
      fx_d = {sample_q[SAMPLE_W-1:0], {ALPHA_SHIFT{1'b0}}};
      fy_d = {sample_q[2*SAMPLE_W-1:SAMPLE_W], {ALPHA_SHIFT{1'b0}}};
    end else begin
      fx_d = iir_step(fx_q, sample_q[SAMPLE_W-1:0]);
      fy_d = iir_step(fy_q, sample_q[2*SAMPLE_W-1:SAMPLE_W]);
    end
  end

  // Filter registers advance once per committed frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fx_q    <= '0;
      fy_q    <= '0;
      finit_q <= 1'b0;
      fvld_q  <= 1'b0;
    end else begin
      fvld_q <= sample_valid_q;
      if (sample_valid_q) begin
        fx_q    <= fx_d;
        fy_q    <= fy_d;
        finit_q <= 1'b1;
      end
    end
  end

  assign map_x   = fx_q[FW-1:ALPHA_SHIFT];
  assign map_y   = fy_q[FW-1:ALPHA_SHIFT];
  assign map_vld = fvld_q;
`else
  logic unused_alpha;
  assign unused_alpha = (ALPHA_SHIFT > 0);
  assign map_x        = sample_q[SAMPLE_W-1:0];
  assign map_y        = sample_q[2*SAMPLE_W-1:SAMPLE_W];
  assign map_vld      = sample_valid_q;
`endif

  // ---------------------------------------------------------------------------
  // Tilt mapping with signed saturation
  // ---------------------------------------------------------------------------
  logic signed [MW-1:0] x_ext, y_ext, c_raw, r_raw;
  logic [CW-1:0]        col_d, col_q;
  logic [RW-1:0]        row_d, row_q;
  logic                 pos_vld_q;

  // Shift, centre and clamp; two guard bits keep the offset add from wrapping.
  always_comb begin
    x_ext = {{2{map_x[SAMPLE_W-1]}}, map_x};
    y_ext = {{2{map_y[SAMPLE_W-1]}}, map_y};
    c_raw = (x_ext >>> COL_SHIFT) + COL_OFF;
    r_raw = (y_ext >>> ROW_SHIFT) + ROW_OFF;
    col_d = c_raw[CW-1:0];
    row_d = r_raw[RW-1:0];
    if (c_raw[MW-1]) begin
      col_d = '0;
    end else if (c_raw > COL_MAX) begin
      col_d = CW'(COLS - 1);
    end
    if (r_raw[MW-1]) begin
      row_d = '0;
    end else if (r_raw > ROW_MAX) begin
      row_d = RW'(ROWS - 1);
    end
  end

  // Index registers hold between updates; pos_valid pulses for one cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_q     <= '0;
      row_q     <= '0;
      pos_vld_q <= 1'b0;
    end else begin
      pos_vld_q <= map_vld;
      if (map_vld) begin
        col_q <= col_d;
        row_q <= row_d;
      end
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign column_index_o = col_q;
  assign row_index_o    = row_q;
  assign pos_valid_o    = pos_vld_q;

endmodule
